busca_instrucao: RTL and testbench

BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

---
 rtl/busca_instrucao.sv | 144 ++++++++++++++
 tb/tb_busca_instrucao.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/busca_instrucao.sv
`default_nettype none
// ============================================================================
// Module      : busca_instrucao
// Description : Instruction fetch unit: reads the word at the current PC,
//               holds it in the IR until decode accepts it, and requests PC+1.
//               Optional delivery counter enabled by macro BUSCA_CONTADOR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module busca_instrucao #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        habilita_busca,
    input  logic [15:0] pc_atual,
    output logic        incrementaPC,
    input  logic        desvio,
    output logic        mem_le,
    output logic [15:0] mem_endereco,
    input  logic        mem_pronto,
    input  logic [15:0] mem_dado,
    output logic [15:0] instrucao,
    output logic        instrucao_valida,
    input  logic        consumidor_pronto,
    output logic        erro_barramento
`ifdef BUSCA_CONTADOR_EN
    ,
    output logic [15:0] contador_buscas
`endif
);

    localparam logic [7:0] c_LIMITE = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        REQUISITA = 3'd1,
        ENTREGA   = 3'd2,
        DESCARTE  = 3'd3,
        ERRO      = 3'd4
    } estado_t;

    estado_t     r_estado;
    logic [7:0]  r_contador_tempo;
    logic        r_mem_le;
    logic        r_inc_pc;
    logic        r_valida;
    logic        r_erro;
    logic [15:0] r_instrucao;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_estado         <= OCIOSO;
            r_contador_tempo <= 8'd0;
            r_mem_le         <= 1'b0;
            r_inc_pc         <= 1'b0;
            r_valida         <= 1'b0;
            r_erro           <= 1'b0;
            r_instrucao      <= 16'h0000;
        end else begin
            r_inc_pc <= 1'b0;
            // A taken branch overrides everything except the terminal error state
            if (desvio && (r_estado != ERRO)) begin
                r_estado         <= DESCARTE;
                r_mem_le         <= 1'b0;
                r_valida         <= 1'b0;
                r_contador_tempo <= 8'd0;
            end else begin
                case (r_estado)
                    OCIOSO: begin
                        if (habilita_busca) begin
                            r_estado <= REQUISITA;
                            r_mem_le <= 1'b1;
                        end
                    end
                    REQUISITA: begin
                        if (mem_pronto) begin
                            r_instrucao      <= mem_dado;
                            r_valida         <= 1'b1;
                            r_inc_pc         <= 1'b1;
                            r_estado         <= ENTREGA;
                            r_mem_le         <= 1'b0;
                            r_contador_tempo <= 8'd0;
                        end else if (r_contador_tempo == c_LIMITE) begin
                            r_estado         <= ERRO;
                            r_mem_le         <= 1'b0;
                            r_erro           <= 1'b1;
                            r_contador_tempo <= 8'd0;
                        end else begin
                            r_contador_tempo <= r_contador_tempo + 8'd1;
                        end
                    end
                    ENTREGA: begin
                        if (consumidor_pronto) begin
                            r_valida <= 1'b0;
                            r_estado <= habilita_busca ? REQUISITA : OCIOSO;
                            r_mem_le <= habilita_busca;
                        end
                    end
                    DESCARTE: begin
                        r_estado <= habilita_busca ? REQUISITA : OCIOSO;
                        r_mem_le <= habilita_busca;
                    end
                    ERRO: begin
                        r_mem_le <= 1'b0;
                        r_valida <= 1'b0;
                    end
                    default: begin
                        r_estado <= OCIOSO;
                        r_mem_le <= 1'b0;
                        r_valida <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef BUSCA_CONTADOR_EN
    logic [15:0] r_contador_buscas;
    logic        w_entrega_aceita;

    // Only a real handshake counts; a concurrent branch turns it into a discard
    assign w_entrega_aceita = (r_estado == ENTREGA) && consumidor_pronto && !desvio;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_contador_buscas <= 16'h0000;
        end else if (w_entrega_aceita) begin
            r_contador_buscas <= r_contador_buscas + 16'd1;
        end
    end

    assign contador_buscas = r_contador_buscas;
`endif

    // The PC register also sees desvio, so the increment is suppressed in that cycle
    assign incrementaPC     = r_inc_pc & ~desvio;
    assign mem_le           = r_mem_le;
    assign mem_endereco     = pc_atual;
    assign instrucao        = r_instrucao;
    assign instrucao_valida = r_valida;
    assign erro_barramento  = r_erro;

endmodule
`default_nettype wire

// File: tb/tb_busca_instrucao.sv
`default_nettype none
// ============================================================================
// Module      : tb_busca_instrucao
// Description : Directed self-checking bench for busca_instrucao (MEM_TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_busca_instrucao;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        habilita_busca;
    logic [15:0] pc_atual = 16'h0010;
    logic        incrementaPC;
    logic        desvio;
    logic        mem_le;
    logic [15:0] mem_endereco;
    logic        mem_pronto;
    logic [15:0] mem_dado;
    logic [15:0] instrucao;
    logic        instrucao_valida;
    logic        consumidor_pronto;
    logic        erro_barramento;
    logic [15:0] alvo;
`ifdef BUSCA_CONTADOR_EN
    logic [15:0] contador_buscas;
`endif

    int n_testes = 0;
    int n_falhas = 0;
    int n_pulsos = 0;

    busca_instrucao #(.MEM_TIMEOUT(4)) dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .habilita_busca    (habilita_busca),
        .pc_atual          (pc_atual),
        .incrementaPC      (incrementaPC),
        .desvio            (desvio),
        .mem_le            (mem_le),
        .mem_endereco      (mem_endereco),
        .mem_pronto        (mem_pronto),
        .mem_dado          (mem_dado),
        .instrucao         (instrucao),
        .instrucao_valida  (instrucao_valida),
        .consumidor_pronto (consumidor_pronto),
        .erro_barramento   (erro_barramento)
`ifdef BUSCA_CONTADOR_EN
        ,
        .contador_buscas   (contador_buscas)
`endif
    );

    always #5 Clock = ~Clock;

    // PC register model: branch target has priority over increment
    always @(posedge Clock) begin
        if (incrementaPC) n_pulsos <= n_pulsos + 1;
        if (desvio) pc_atual <= alvo;
        else if (incrementaPC) pc_atual <= pc_atual + 16'd1;
    end

    task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
        n_testes++;
        if (obtido !== esperado) begin
            n_falhas++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obtido, esperado);
        end
    endtask

    initial begin
        Reset = 1'b1; habilita_busca = 1'b0; desvio = 1'b0; mem_pronto = 1'b0;
        mem_dado = 16'h0000; consumidor_pronto = 1'b0; alvo = 16'h0000;
        #1;
        verifica("rst_mem_le", mem_le, 0);
        verifica("rst_valida", instrucao_valida, 0);
        verifica("rst_instrucao", instrucao, 16'h0000);
        verifica("rst_inc", incrementaPC, 0);
        verifica("rst_erro", erro_barramento, 0);

        // First fetch at 0x0010, memory answers on the second request cycle
        @(negedge Clock); Reset = 1'b0; habilita_busca = 1'b1;
        @(negedge Clock);
        verifica("req_mem_le", mem_le, 1);
        verifica("req_endereco", mem_endereco, 16'h0010);
        @(negedge Clock);
        verifica("req_espera", mem_le, 1);
        mem_pronto = 1'b1; mem_dado = 16'hA5A5;
        @(negedge Clock);
        mem_pronto = 1'b0; mem_dado = 16'h0000;
        verifica("ent_instrucao", instrucao, 16'hA5A5);
        verifica("ent_valida", instrucao_valida, 1);
        verifica("ent_inc", incrementaPC, 1);
        verifica("ent_mem_le", mem_le, 0);

        // Decode stalls for five cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            verifica("hold_instrucao", instrucao, 16'hA5A5);
            verifica("hold_valida", instrucao_valida, 1);
            verifica("hold_mem_le", mem_le, 0);
            verifica("hold_inc", incrementaPC, 0);
        end
        verifica("pulso_unico", n_pulsos, 1);
        consumidor_pronto = 1'b1;
        @(negedge Clock);
        consumidor_pronto = 1'b0;
        verifica("aceite_valida", instrucao_valida, 0);
        verifica("aceite_mem_le", mem_le, 1);
        verifica("aceite_endereco", mem_endereco, 16'h0011);

        // Branch in the same cycle as memory ready
        mem_pronto = 1'b1; mem_dado = 16'h1234; desvio = 1'b1; alvo = 16'h0200;
        #1 verifica("desvio_inc", incrementaPC, 0);
        @(negedge Clock);
        mem_pronto = 1'b0; desvio = 1'b0;
        verifica("desc_valida", instrucao_valida, 0);
        verifica("desc_mem_le", mem_le, 0);
        verifica("desc_instrucao", instrucao, 16'hA5A5);
        verifica("desc_inc", incrementaPC, 0);
        @(negedge Clock);
        verifica("alvo_mem_le", mem_le, 1);
        verifica("alvo_endereco", mem_endereco, 16'h0200);
        verifica("alvo_pulsos", n_pulsos, 1);

        // Branch and accept together: the branch wins, increment is masked
        mem_pronto = 1'b1; mem_dado = 16'hBEEF;
        @(negedge Clock);
        mem_pronto = 1'b0;
        verifica("ent2_valida", instrucao_valida, 1);
        verifica("ent2_inc", incrementaPC, 1);
        desvio = 1'b1; consumidor_pronto = 1'b1; alvo = 16'h0300;
        #1 verifica("desvio_mascara_inc", incrementaPC, 0);
        @(negedge Clock);
        desvio = 1'b0; consumidor_pronto = 1'b0; habilita_busca = 1'b0;
        verifica("dc_valida", instrucao_valida, 0);
        verifica("dc_mem_le", mem_le, 0);
        verifica("dc_pulsos", n_pulsos, 1);
        @(negedge Clock);
        verifica("ocioso_mem_le", mem_le, 0);

        // Enable drops mid-read: delivery completes, then idle
        habilita_busca = 1'b1;
        @(negedge Clock);
        verifica("hab_req", mem_le, 1);
        verifica("hab_endereco", mem_endereco, 16'h0300);
        habilita_busca = 1'b0; mem_pronto = 1'b1; mem_dado = 16'hCAFE;
        @(negedge Clock);
        mem_pronto = 1'b0;
        verifica("hab_instrucao", instrucao, 16'hCAFE);
        verifica("hab_valida", instrucao_valida, 1);
        consumidor_pronto = 1'b1;
        @(negedge Clock);
        consumidor_pronto = 1'b0;
        verifica("hab_fim_valida", instrucao_valida, 0);
        verifica("hab_fim_mem_le", mem_le, 0);
        @(negedge Clock);
        verifica("hab_ocioso", mem_le, 0);

        // Asynchronous reset between edges during a read
        habilita_busca = 1'b1;
        @(negedge Clock);
        verifica("rst2_req", mem_le, 1);
        #2 Reset = 1'b1;
        #1;
        verifica("rst_async_mem_le", mem_le, 0);
        verifica("rst_async_valida", instrucao_valida, 0);
        #1 Reset = 1'b0; mem_pronto = 1'b1; mem_dado = 16'hDEAD;
        @(negedge Clock);
        mem_pronto = 1'b0;
        verifica("late_valida", instrucao_valida, 0);
        verifica("late_mem_le", mem_le, 1);
        verifica("late_instrucao", instrucao, 16'h0000);

        // Memory never answers: error after four request cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            verifica("to_espera", mem_le, 1);
            verifica("to_sem_erro", erro_barramento, 0);
        end
        @(negedge Clock);
        verifica("to_erro", erro_barramento, 1);
        verifica("to_mem_le", mem_le, 0);
        verifica("to_valida", instrucao_valida, 0);
        desvio = 1'b1; mem_pronto = 1'b1; consumidor_pronto = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            verifica("erro_persiste", erro_barramento, 1);
            verifica("erro_mem_le", mem_le, 0);
        end
        desvio = 1'b0; mem_pronto = 1'b0; consumidor_pronto = 1'b0;
        Reset = 1'b1;
        #1 verifica("erro_limpo", erro_barramento, 0);
        @(negedge Clock); Reset = 1'b0;

`ifdef BUSCA_CONTADOR_EN
        verifica("cont_zero", contador_buscas, 0);
        @(negedge Clock);
        for (int i = 0; i < 3; i++) begin
            mem_pronto = 1'b1;
            @(negedge Clock);
            mem_pronto = 1'b0; consumidor_pronto = 1'b1;
            @(negedge Clock);
            consumidor_pronto = 1'b0;
        end
        mem_pronto = 1'b1;
        @(negedge Clock);
        mem_pronto = 1'b0; desvio = 1'b1; consumidor_pronto = 1'b1;
        @(negedge Clock);
        desvio = 1'b0; consumidor_pronto = 1'b0;
        @(negedge Clock);
        verifica("cont_tres", contador_buscas, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule
`default_nettype wire
